// File: rtl/aes_round_seq_pkg.sv
// Shared types and constants for the iterative AES-128 round sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package aes_round_seq_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] block_t;
    typedef logic [3:0]   rnd_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } aes_seq_state_e;

endpackage

// File: rtl/aes_round_seq.sv
// Iterative AES-128 controller: drives one shared round unit for rounds 0..NR, then returns the ciphertext.
// Latency: o_valid rises 1 + (NR+1)*(L+1) cycles after accept, L = round-unit latency (>= 1).
// Backpressure: o_ready only in IDLE; ciphertext held in DONE until i_ready. Optional AES_SEQ_TIMEOUT_EN adds a round-unit watchdog.
module aes_round_seq
    import aes_round_seq_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int TIMEOUT = 64
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     i_valid,
    output logic     o_ready,
    input  block_t   i_plain,
    input  block_t   i_key,
    output logic     o_valid,
    input  logic     i_ready,
    output block_t   o_cipher,
    output logic     o_rnd_tx_en,
    output rnd_idx_t o_rnd_idx,
    output block_t   o_rnd_state,
    output block_t   o_rnd_key,
    input  logic     i_rnd_tx_en,
    input  block_t   i_rnd_state,
    input  block_t   i_rnd_key,
    output logic     o_err
);

    aes_seq_state_e fsm_q, fsm_d;
    rnd_idx_t       round_q;
    block_t         state_q;
    block_t         key_q;
    logic           last_rnd;
    logic           accept;
    logic           wd_expire;

    assign last_rnd = (round_q == rnd_idx_t'(NR));
    assign accept   = i_valid && o_ready;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // The count would reach TIMEOUT on this edge; a same-cycle response takes priority.
    assign wd_expire = (fsm_q == WAIT) && !i_rnd_tx_en && (wd_q == WD_W'(TIMEOUT - 1));

    // Watchdog: cleared in ISSUE (the only way into WAIT), counts WAIT cycles, error is sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (fsm_q == ISSUE) begin
                wd_q <= '0;
            end else if ((fsm_q == WAIT) && !i_rnd_tx_en) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_err = err_q;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wd_expire      = 1'b0;
    assign o_err          = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic; done pulses outside WAIT are ignored.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:  if (accept) fsm_d = ISSUE;
            ISSUE: fsm_d = WAIT;
            WAIT: begin
                if (i_rnd_tx_en) begin
                    fsm_d = last_rnd ? DONE : ISSUE;
                end else if (wd_expire) begin
                    fsm_d = IDLE;
                end
            end
            DONE:  if (i_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Round state, round key and round index; loaded on accept, replaced by each round result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            round_q <= '0;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= i_plain;
                        key_q   <= i_key;
                        round_q <= '0;
                    end
                end
                WAIT: begin
                    if (i_rnd_tx_en) begin
                        state_q <= i_rnd_state;
                        key_q   <= i_rnd_key;
                        // Saturate at NR so the index never wraps.
                        if (!last_rnd) begin
                            round_q <= round_q + rnd_idx_t'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Request side is closed while reset is asserted even though the FSM already sits in IDLE.
    assign o_ready     = (fsm_q == IDLE) && !reset;
    assign o_valid     = (fsm_q == DONE);
    assign o_cipher    = o_valid ? state_q : '0;
    assign o_rnd_tx_en = (fsm_q == ISSUE);
    assign o_rnd_idx   = round_q;
    assign o_rnd_state = state_q;
    assign o_rnd_key   = key_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Testbench for aes_round_seq with a behavioural AES round unit attached to the round ports.
// Latency: checks accept-to-valid timing against 1 + (NR+1)*(L+1).
// Backpressure: exercises held i_ready, stray done pulses, mid-run reset and the AES_SEQ_TIMEOUT_EN watchdog.
module tb_aes_round_seq;
    import aes_round_seq_pkg::*;

    localparam int NR = AES_NR;
    localparam int TO = 8;

    logic     clock = 1'b0;
    logic     reset = 1'b1;
    logic     i_valid = 1'b0;
    logic     o_ready;
    block_t   i_plain = '0;
    block_t   i_key = '0;
    logic     o_valid;
    logic     i_ready = 1'b0;
    block_t   o_cipher;
    logic     o_rnd_tx_en;
    rnd_idx_t o_rnd_idx;
    block_t   o_rnd_state;
    block_t   o_rnd_key;
    logic     i_rnd_tx_en;
    block_t   i_rnd_state;
    block_t   i_rnd_key;
    logic     o_err;

    logic   resp_pulse = 1'b0;
    logic   stray_pulse = 1'b0;
    block_t resp_state = '0;
    block_t resp_key = '0;
    block_t stray_state = '0;
    block_t stray_key = '0;

    assign i_rnd_tx_en = resp_pulse | stray_pulse;
    assign i_rnd_state = stray_pulse ? stray_state : resp_state;
    assign i_rnd_key   = stray_pulse ? stray_key : resp_key;

    always #5 clock = ~clock;

    aes_round_seq #(.NR(NR), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .o_ready(o_ready), .i_plain(i_plain), .i_key(i_key),
        .o_valid(o_valid), .i_ready(i_ready), .o_cipher(o_cipher),
        .o_rnd_tx_en(o_rnd_tx_en), .o_rnd_idx(o_rnd_idx),
        .o_rnd_state(o_rnd_state), .o_rnd_key(o_rnd_key),
        .i_rnd_tx_en(i_rnd_tx_en), .i_rnd_state(i_rnd_state), .i_rnd_key(i_rnd_key),
        .o_err(o_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- AES reference (FIPS-197) ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input block_t s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic block_t sub_shift(input block_t s);
        block_t o;
        int     src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            o[127-8*i -: 8] = sbox[gb(s, src)];
        end
        return o;
    endfunction

    function automatic block_t mix_cols(input block_t s);
        block_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                 a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                 a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                 gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
        return o;
    endfunction

    // Round key r -> round key r+1.
    function automatic block_t next_key(input block_t k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        repeat (r) rc = gmul(rc, 8'h02);
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic block_t aes_ref(input block_t p, input block_t k);
        block_t s;
        s = p ^ k;
        for (int r = 1; r <= NR; r++) begin
            k = next_key(k, r - 1);
            s = (r == NR) ? (sub_shift(s) ^ k) : (mix_cols(sub_shift(s)) ^ k);
        end
        return s;
    endfunction

    // ---------------- Round-unit responder ----------------
    int     resp_lat = 1;
    bit     resp_en = 1'b1;
    bit     pend = 1'b0;
    int     cnt = 0;
    int     cap_idx = 0;
    block_t cap_state = '0;
    block_t cap_key = '0;
    int     idx_log[$];

    always begin
        @(posedge clock);
        #1;
        resp_pulse = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                if (cap_idx == 0)       resp_state = cap_state ^ cap_key;
                else if (cap_idx == NR) resp_state = sub_shift(cap_state) ^ cap_key;
                else                    resp_state = mix_cols(sub_shift(cap_state)) ^ cap_key;
                resp_key   = next_key(cap_key, cap_idx);
                resp_pulse = 1'b1;
                pend       = 1'b0;
            end
        end
        if (o_rnd_tx_en) begin
            cap_idx   = int'(o_rnd_idx);
            cap_state = o_rnd_state;
            cap_key   = o_rnd_key;
            idx_log.push_back(cap_idx);
            pend = resp_en;
            cnt  = resp_lat;
        end
    end

    // ---------------- Transaction helpers ----------------
    task automatic start_txn(input block_t p, input block_t k);
        int n;
        @(negedge clock);
        i_plain = p; i_key = k; i_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("accept_ready", o_ready, 1'b1);
        @(negedge clock);
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!o_valid && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic stray(input block_t s, input block_t k);
        stray_state = s; stray_key = k; stray_pulse = 1'b1;
        @(negedge clock);
        stray_pulse = 1'b0;
    endtask

    task automatic run_txn(input string tag, input block_t p, input block_t k,
                           input int lat, input int hold, input block_t exp);
        int     cyc, bad, unstable;
        block_t c0;
        resp_lat = lat;
        idx_log.delete();
        start_txn(p, k);
        wait_valid(cyc);
        check({tag, "_latency"}, cyc, 1 + (NR + 1) * (lat + 1));
        check({tag, "_cipher"}, o_cipher, exp);
        bad = 0;
        if (idx_log.size() != NR + 1) bad = 100;
        else for (int i = 0; i <= NR; i++) if (bad == 0 && idx_log[i] != i) bad = i + 1;
        check({tag, "_idx_seq"}, bad, 0);
        // Hold i_ready low with a competing request pending.
        c0 = o_cipher;
        unstable = 0;
        i_plain = ~p; i_key = ~k; i_valid = 1'b1;
        repeat (hold) begin
            @(negedge clock);
            if (!o_valid || o_cipher !== c0 || o_ready || o_rnd_tx_en) unstable++;
        end
        check({tag, "_done_hold"}, unstable, 0);
        i_ready = 1'b1;
        @(negedge clock);
        check({tag, "_handshake_idle"}, {o_valid, o_ready, o_rnd_tx_en}, 3'b010);
        i_valid = 1'b0; i_ready = 1'b0;
        @(negedge clock);
        check({tag, "_no_late_accept"}, {o_ready, o_rnd_tx_en}, 2'b10);
    endtask

    typedef struct {
        block_t plain;
        block_t key;
        int     lat;
        int     hold;
        block_t exp;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t   vecs[3];
        logic [7:0] inv;
        block_t p, k, s0, k0;
        int     n, cyc, noisy, bad_valid;

        for (int x = 0; x < 256; x++) begin
            inv = '0;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(x));
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    1, 5, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    3, 2, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    4, 0, 128'h3925841d02dc09fbdc118597196a0b32};

        // Reset state.
        repeat (2) @(negedge clock);
        check("reset_ctl", {o_ready, o_valid, o_rnd_tx_en, o_err, o_rnd_idx}, 8'h00);
        check("reset_bus", o_cipher | o_rnd_state | o_rnd_key, '0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", o_ready, 1'b1);

        // Known-answer vectors.
        for (int i = 0; i < 3; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].plain, vecs[i].key, vecs[i].lat, vecs[i].hold, vecs[i].exp);
        end

        // Random plaintext/key, latency and consumer stall.
        for (int i = 0; i < 6; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            run_txn($sformatf("rnd%0d", i), p, k, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), aes_ref(p, k));
        end

        // Stray done pulse in IDLE.
        s0 = o_rnd_state; k0 = o_rnd_key;
        stray({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        @(negedge clock);
        check("stray_idle_state", o_rnd_state, s0);
        check("stray_idle_key", o_rnd_key, k0);
        check("stray_idle_ctl", {o_ready, o_valid, o_rnd_tx_en, o_rnd_idx}, {3'b100, 4'(NR)});

        // Stray done pulse in DONE.
        resp_lat = 1;
        start_txn(vecs[0].plain, vecs[0].key);
        wait_valid(cyc);
        stray('1, '1);
        @(negedge clock);
        check("stray_done_cipher", o_cipher, vecs[0].exp);
        check("stray_done_ctl", {o_valid, o_ready, o_rnd_tx_en, o_rnd_idx}, {3'b100, 4'(NR)});
        i_ready = 1'b1;
        @(negedge clock);
        i_ready = 1'b0;

        // Reset during WAIT of round 4; the in-flight response lands after reset.
        resp_lat = 3;
        start_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        n = 0;
        while (!(o_rnd_idx == 4'd4 && !o_rnd_tx_en) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("reach_round4_wait", {o_rnd_idx, o_rnd_tx_en, o_valid}, {4'd4, 2'b00});
        reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_ctl", {o_ready, o_valid, o_rnd_tx_en, o_err, o_rnd_idx}, 8'h00);
        reset = 1'b0;
        noisy = 0;
        repeat (6) begin
            @(negedge clock);
            if (o_valid || o_rnd_tx_en || !o_ready || o_rnd_idx != 4'd0 ||
                o_cipher != '0 || o_rnd_state != '0 || o_rnd_key != '0) noisy++;
        end
        stray('1, '1);
        @(negedge clock);
        if (o_valid || o_rnd_tx_en || !o_ready || o_rnd_state != '0 || o_rnd_key != '0) noisy++;
        check("post_reset_quiet", noisy, 0);

        // Round unit never answers.
        resp_en = 1'b0;
        start_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        bad_valid = 0;
`ifdef AES_SEQ_TIMEOUT_EN
        cyc = 1;
        while (!o_err && cyc < 200) begin
            @(negedge clock);
            if (o_valid) bad_valid++;
            cyc++;
        end
        check("timeout_cycles", cyc, TO + 2);
        check("timeout_idle", {o_ready, o_valid}, 2'b10);
        repeat (3) begin
            @(negedge clock);
            if (o_valid) bad_valid++;
        end
        check("timeout_sticky_err", o_err, 1'b1);
`else
        repeat (40) begin
            @(negedge clock);
            if (o_valid || o_err) bad_valid++;
        end
        check("no_timeout_stuck", {o_ready, o_valid, o_err, o_rnd_idx}, 7'h00);
`endif
        check("stall_no_valid", bad_valid, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        resp_en = 1'b1;
        @(negedge clock);
        check("final_reset_err", {o_err, o_ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
